// File: rtl/bidir_shift_register.sv
// Bidirectional DEPTH x WIDTH shift register: hold / shift left / shift right / parallel load,
// with fill counter and primed flag. Optional rotate input under BIDIR_SHIFT_REGISTER_ROTATE_EN.
module bidir_shift_register #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [1:0]                     mode,
`ifdef BIDIR_SHIFT_REGISTER_ROTATE_EN
    input  logic                           rot,
`endif
    input  logic [WIDTH-1:0]               l_in,
    input  logic [WIDTH-1:0]               r_in,
    input  logic [WIDTH*DEPTH-1:0]         par_in,
    output logic [WIDTH-1:0]               l_out,
    output logic [WIDTH-1:0]               r_out,
    output logic [WIDTH*DEPTH-1:0]         par_out,
    output logic [$clog2(DEPTH+1)-1:0]     fill,
    output logic                           primed
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam int TW = WIDTH * DEPTH;
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Stage i lives in stage_q[i*WIDTH +: WIDTH], so stage 0 is the low slice.
    logic [TW-1:0]    stage_q, stage_next;
    logic [FW-1:0]    fill_q, fill_next, fill_inc;
    logic             primed_q;
    logic [WIDTH-1:0] left_feed, right_feed;

    always_comb begin
        left_feed  = l_in;
        right_feed = r_in;
`ifdef BIDIR_SHIFT_REGISTER_ROTATE_EN
        if (rot) begin
            left_feed  = stage_q[TW-1 -: WIDTH];
            right_feed = stage_q[WIDTH-1:0];
        end
`endif
    end

    assign fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);

    always_comb begin
        stage_next = stage_q;
        fill_next  = fill_q;
        case (mode)
            MODE_HOLD: begin
                stage_next = stage_q;
                fill_next  = fill_q;
            end
            MODE_LEFT: begin
                stage_next = {stage_q[TW-WIDTH-1:0], left_feed};
                fill_next  = fill_inc;
            end
            MODE_RIGHT: begin
                stage_next = {right_feed, stage_q[TW-1:WIDTH]};
                fill_next  = fill_inc;
            end
            MODE_LOAD: begin
                stage_next = par_in;
                fill_next  = FILL_FULL;
            end
            default: begin
                stage_next = stage_q;
                fill_next  = fill_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q  <= '0;
            fill_q   <= '0;
            primed_q <= 1'b0;
        end else if (enable) begin
            stage_q  <= stage_next;
            fill_q   <= fill_next;
            primed_q <= (fill_next == FILL_FULL);
        end
    end

    assign l_out   = stage_q[TW-1 -: WIDTH];
    assign r_out   = stage_q[WIDTH-1:0];
    assign par_out = stage_q;
    assign fill    = fill_q;
    assign primed  = primed_q;

endmodule

// File: tb/tb_bidir_shift_register.sv
// Directed bench for bidir_shift_register: 8x1 instance for control/delay-line behaviour,
// 4x4 instance for multi-bit packing; rotate steps when BIDIR_SHIFT_REGISTER_ROTATE_EN is set.
module tb_bidir_shift_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-stage, 1-bit instance
    logic       a_reset, a_enable;
    logic [1:0] a_mode;
    logic       a_rot;
    logic       a_l_in, a_r_in;
    logic [7:0] a_par_in;
    logic       a_l_out, a_r_out;
    logic [7:0] a_par_out;
    logic [3:0] a_fill;
    logic       a_primed;

    // 4-stage, 4-bit instance
    logic        b_reset, b_enable;
    logic [1:0]  b_mode;
    logic        b_rot;
    logic [3:0]  b_l_in, b_r_in;
    logic [15:0] b_par_in;
    logic [3:0]  b_l_out, b_r_out;
    logic [15:0] b_par_out;
    logic [2:0]  b_fill;
    logic        b_primed;

    bidir_shift_register #(.DEPTH(8), .WIDTH(1)) dut_a (
        .clk     (clk),
        .reset   (a_reset),
        .enable  (a_enable),
        .mode    (a_mode),
`ifdef BIDIR_SHIFT_REGISTER_ROTATE_EN
        .rot     (a_rot),
`endif
        .l_in    (a_l_in),
        .r_in    (a_r_in),
        .par_in  (a_par_in),
        .l_out   (a_l_out),
        .r_out   (a_r_out),
        .par_out (a_par_out),
        .fill    (a_fill),
        .primed  (a_primed)
    );

    bidir_shift_register #(.DEPTH(4), .WIDTH(4)) dut_b (
        .clk     (clk),
        .reset   (b_reset),
        .enable  (b_enable),
        .mode    (b_mode),
`ifdef BIDIR_SHIFT_REGISTER_ROTATE_EN
        .rot     (b_rot),
`endif
        .l_in    (b_l_in),
        .r_in    (b_r_in),
        .par_in  (b_par_in),
        .l_out   (b_l_out),
        .r_out   (b_r_out),
        .par_out (b_par_out),
        .fill    (b_fill),
        .primed  (b_primed)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] seq;
    logic       exp_l;

    initial begin
        a_reset = 1'b1; a_enable = 1'b1; a_mode = 2'b11; a_rot = 1'b0;
        a_l_in = 1'b1; a_r_in = 1'b1; a_par_in = 8'hFF;
        b_reset = 1'b1; b_enable = 1'b1; b_mode = 2'b00; b_rot = 1'b0;
        b_l_in = 4'h0; b_r_in = 4'h0; b_par_in = 16'h0000;

        // Reset wins over a parallel load on the same edge
        tick();
        chk("rst_l_out",   a_l_out,   0);
        chk("rst_r_out",   a_r_out,   0);
        chk("rst_par_out", a_par_out, 8'h00);
        chk("rst_fill",    a_fill,    0);
        chk("rst_primed",  a_primed,  0);

        a_reset = 1'b0; a_enable = 1'b0; a_mode = 2'b11; a_par_in = 8'hFF;
        tick(); tick(); tick();
        chk("dis_par_out", a_par_out, 8'h00);
        chk("dis_fill",    a_fill,    0);

        // Left delay line: 1,0,0,1,0,1,0,1 then zeros; r_in held high and ignored
        seq = 8'b1010_1001;
        a_enable = 1'b1; a_mode = 2'b01; a_r_in = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            a_l_in = (k <= 8) ? seq[k-1] : 1'b0;
            tick();
            exp_l = (k >= 8) ? seq[k-8] : 1'b0;
            chk($sformatf("dl_l_out_%0d", k), a_l_out, exp_l);
            chk($sformatf("dl_fill_%0d", k),  a_fill,  (k >= 8) ? 8 : k);
            chk($sformatf("dl_primed_%0d", k), a_primed, (k >= 8) ? 1 : 0);
        end
        chk("dl_par_out", a_par_out, 8'h80);

        a_mode = 2'b00; a_l_in = 1'b1;
        tick();
        chk("hold_par_out", a_par_out, 8'h80);
        chk("hold_fill",    a_fill,    8);

        a_enable = 1'b0; a_mode = 2'b01;
        tick();
        chk("en0_par_out", a_par_out, 8'h80);
        a_enable = 1'b1;

        // Load, shift right, reverse
        a_mode = 2'b11; a_par_in = 8'b1000_0001;
        tick();
        chk("ld_par_out", a_par_out, 8'b1000_0001);
        chk("ld_fill",    a_fill,    8);
        chk("ld_primed",  a_primed,  1);

        a_mode = 2'b10; a_r_in = 1'b0; a_l_in = 1'b1; a_par_in = 8'hFF;
        tick();
        chk("sr_par_out", a_par_out, 8'b0100_0000);
        chk("sr_r_out",   a_r_out,   0);

        a_mode = 2'b01; a_l_in = 1'b1; a_r_in = 1'b0;
        tick();
        chk("rev_par_out", a_par_out, 8'b1000_0001);
        chk("rev_fill",    a_fill,    8);

        a_mode = 2'b10; a_r_in = 1'b1; a_l_in = 1'b0;
        tick();
        chk("sr1_par_out", a_par_out, 8'b1100_0000);
        chk("sr1_l_out",   a_l_out,   1);

        // Reset mid-operation
        a_reset = 1'b1; a_mode = 2'b00;
        tick();
        a_reset = 1'b0; a_mode = 2'b01; a_l_in = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_par_out", a_par_out, 8'b0001_1111);
        chk("pre_fill",    a_fill,    5);
        chk("pre_primed",  a_primed,  0);

        a_reset = 1'b1;
        tick();
        chk("mid_par_out", a_par_out, 8'h00);
        chk("mid_fill",    a_fill,    0);
        chk("mid_primed",  a_primed,  0);

        a_reset = 1'b0;
        tick();
        chk("resume_par_out", a_par_out, 8'h01);
        chk("resume_fill",    a_fill,    1);

        a_mode = 2'b10; a_r_in = 1'b1; a_l_in = 1'b0;
        tick();
        chk("resume_sr_par_out", a_par_out, 8'h80);
        chk("resume_sr_fill",    a_fill,    2);

`ifdef BIDIR_SHIFT_REGISTER_ROTATE_EN
        a_mode = 2'b11; a_par_in = 8'b0000_0011;
        tick();
        a_mode = 2'b01; a_rot = 1'b1; a_l_in = 1'b0;
        tick();
        chk("rotl1_par_out", a_par_out, 8'b0000_0110);
        for (int k = 0; k < 7; k++) tick();
        chk("rotl8_par_out", a_par_out, 8'b0000_0011);
        chk("rotl8_fill",    a_fill,    8);
        a_mode = 2'b10; a_r_in = 1'b0;
        tick();
        chk("rotr_par_out", a_par_out, 8'b1000_0001);
        a_rot = 1'b0;
`endif

        // Multi-bit instance
        b_reset = 1'b0; b_mode = 2'b01;
        b_l_in = 4'hA; tick();
        b_l_in = 4'hB; tick();
        b_l_in = 4'hC; tick();
        b_l_in = 4'hD; tick();
        chk("mb_par_out", b_par_out, 16'hABCD);
        chk("mb_l_out",   b_l_out,   4'hA);
        chk("mb_r_out",   b_r_out,   4'hD);
        chk("mb_fill",    b_fill,    4);
        chk("mb_primed",  b_primed,  1);

        b_mode = 2'b10; b_r_in = 4'hE; b_l_in = 4'h5;
        tick();
        chk("mb_sr_par_out", b_par_out, 16'hEABC);
        chk("mb_sr_r_out",   b_r_out,   4'hC);
        chk("mb_sr_fill",    b_fill,    4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bidir_shift_register.md
Name: bidir_shift_register

Overview:
- Parametrised successor to the single-direction serial shift registers.
- One DEPTH-stage, WIDTH-bit-per-stage register supporting hold, shift-left, shift-right and parallel load, selected per cycle.
- Provides serial in/out at both ends, a full parallel view, and a fill counter with a "primed" flag.
- Used as a generic delay line, serialiser/deserialiser and bidirectional buffer in datapath blocks.

Parameters:
- DEPTH, 8, number of stages; legal range >= 2.
- WIDTH, 1, bits per stage.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when 0, all state holds regardless of mode.
- mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
- l_in  input  WIDTH  serial input for left shift; enters stage 0.
- r_in  input  WIDTH  serial input for right shift; enters stage DEPTH-1.
- par_in  input  WIDTH*DEPTH  parallel load data; stage i = par_in[i*WIDTH +: WIDTH].
- l_out  output  WIDTH  equals stage[DEPTH-1].
- r_out  output  WIDTH  equals stage[0].
- par_out  output  WIDTH*DEPTH  all stages, same packing as par_in.
- fill  output  $clog2(DEPTH+1)  shifts since last reset/load, saturating at DEPTH.
- primed  output  1  high when fill == DEPTH.

Behaviour:
- Storage is stage[0..DEPTH-1]. All outputs are direct register views; there is no combinational path from inputs to outputs.
- Reset (reset=1 at a rising edge) takes priority over everything:
  - all stages = 0, fill = 0, primed = 0;
  - l_out, r_out and par_out are therefore 0;
  - applies mid-operation; the next cycle starts from the empty state.
- enable=0 and reset=0: everything holds.
- enable=1 and reset=0, action by mode:
  - 00: hold; fill unchanged.
  - 01: stage[i] <= stage[i-1] for i>0, stage[0] <= l_in. The value on l_in appears on l_out exactly DEPTH edges later. fill <= min(fill+1, DEPTH).
  - 10: stage[i] <= stage[i+1] for i<DEPTH-1, stage[DEPTH-1] <= r_in. The value appears on r_out DEPTH edges later. fill <= min(fill+1, DEPTH).
  - 11: stage[i] <= par_in slice i; fill <= DEPTH.
- Direction reversal mid-stream is legal: data already stored is kept and the shift proceeds from the current contents. fill keeps counting and is not cleared.
- fill saturates at DEPTH and never wraps. primed is registered and updates on the same edge as fill.
- l_in and r_in are ignored in every mode except their own shift mode. par_in is ignored except in mode 11.

Optional Feature:
- Macro BIDIR_SHIFT_REGISTER_ROTATE_EN.
- Defined: adds input port rot (1 bit).
  - rot=1 with mode 01: stage[0] <= stage[DEPTH-1] (rotate left).
  - rot=1 with mode 10: stage[DEPTH-1] <= stage[0] (rotate right).
  - In both cases the serial input is ignored and fill updates as for a normal shift.
  - rot is ignored in modes 00 and 11.
- Undefined: no rot port; shifts always take the serial input.

Test Plan:
- Reset/enable: DEPTH=8, WIDTH=1. Assert reset for one edge with enable=1 -> l_out=r_out=0, par_out=8'h00, fill=0, primed=0. Then set enable=0, mode=11, par_in=8'hFF for 3 edges -> par_out stays 8'h00.
- Left delay line: mode=01, l_in sequence 1,0,0,1,0,1,0,1 then zeros.
  - l_out follows the same sequence, starting at the 8th edge after the first 1 was captured.
  - fill counts 1..8; primed rises on the 8th edge and stays high.
- Right shift and reversal:
  - Load par_in=8'b1000_0001 -> fill=8, primed=1.
  - mode=10 with r_in=0 for 1 edge -> par_out=8'b0100_0000, r_out=0.
  - mode=01 with l_in=1 for 1 edge -> par_out=8'b1000_0001.
- Multi-bit: WIDTH=4, DEPTH=4. Shift left 4'hA, 4'hB, 4'hC, 4'hD -> par_out=16'hABCD (stage3 = A), l_out=4'hA.
- Reset mid-operation: after 5 left shifts of 1s, assert reset with mode=01 and l_in=1 -> all zero and fill=0 on that edge. Shifting resumes from empty on the next edge.
- Rotate (macro defined): load 8'b0000_0011, mode=01, rot=1 for 8 edges -> par_out returns to 8'b0000_0011; after 1 edge it reads 8'b0000_0110.
